cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder_pkg.sv | 41 ++++
 rtl/cpu_mem_responder_mmio_regs.sv | 103 ++++++++++
 rtl/cpu_mem_responder.sv | 130 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory-side responder: default geometry,
// MMIO register offsets, request direction encoding and FSM states.
package cpu_mem_responder_pkg;

  // Default geometry of the responder.
  localparam int unsigned CPU_ADDR_WIDTH     = 16;
  localparam int unsigned CPU_DATA_WIDTH     = 8;
  localparam int unsigned CPU_MEM_DEPTH_LOG2 = 12;
  localparam logic [15:0] CPU_MMIO_BASE      = 16'hFF00;

  // The MMIO window is 8 bytes, so 3 offset bits select a register.
  localparam int unsigned MMIO_OFF_W = 3;

  // Register offsets inside the MMIO window.
  localparam logic [MMIO_OFF_W-1:0] MMIO_OFF_STATUS  = 3'd0;
  localparam logic [MMIO_OFF_W-1:0] MMIO_OFF_SCRATCH = 3'd1;
  localparam logic [MMIO_OFF_W-1:0] MMIO_OFF_CNT_LO  = 3'd2;
  localparam logic [MMIO_OFF_W-1:0] MMIO_OFF_CNT_HI  = 3'd3;
  localparam logic [MMIO_OFF_W-1:0] MMIO_OFF_DBG     = 3'd4;

  // Free-running cycle counter width.
  localparam int unsigned CYCLE_CNT_W = 16;

  // CPU request direction.
  typedef enum logic {
    ENUM__CPU_WH_RDWR__READ  = 1'b0,
    ENUM__CPU_WH_RDWR__WRITE = 1'b1
  } cpu_wh_rdwr_e;

  // Responder FSM: sweep RAM to zero, then serve requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } cmr_state_e;

  // Status register layout: bit0 = sticky error, bit1 = ready.
  function automatic logic [1:0] status_bits(input logic err, input logic ready);
    return {ready, err};
  endfunction

endpackage

// File: rtl/cpu_mem_responder_mmio_regs.sv
// MMIO register block of the responder: status/error, scratch, cycle counter
// with a high-byte shadow, and a debug byte port with a write strobe.
// Returns combinational read data plus a window hit flag for the top decoder.
module cpu_mmio_regs
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = CPU_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(CPU_MMIO_BASE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,        // request valid and responder running
  input  logic                  we_i,        // 1 = write, 0 = read
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  ready_i,     // reflected in status bit1
  input  logic                  err_set_i,   // unmapped access seen this cycle
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  hit_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] dbg_out_o,
  output logic                  dbg_strobe_o
);

  logic                   err_q,     err_d;
  logic [DATA_WIDTH-1:0]  scratch_q, scratch_d;
  logic [CYCLE_CNT_W-1:0] counter_q, counter_d;
  logic [7:0]             shadow_q,  shadow_d;
  logic [DATA_WIDTH-1:0]  dbg_q,     dbg_d;
  logic                   strobe_q,  strobe_d;

  logic [MMIO_OFF_W-1:0]  off;
  logic                   wr_acc;
  logic                   rd_acc;

  // The window base is 8-byte aligned, so the hit is an upper-bit match.
  assign hit_o  = (addr_i[ADDR_WIDTH-1:MMIO_OFF_W] == MMIO_BASE[ADDR_WIDTH-1:MMIO_OFF_W]);
  assign off    = addr_i[MMIO_OFF_W-1:0];
  assign wr_acc = en_i && hit_o && we_i;
  assign rd_acc = en_i && hit_o && !we_i;

  // Next-state for every register; an unmapped access beats an error clear.
  always_comb begin
    err_d     = err_q;
    scratch_d = scratch_q;
    counter_d = counter_q + 1'b1;
    shadow_d  = shadow_q;
    dbg_d     = dbg_q;
    strobe_d  = 1'b0;
    if (wr_acc) begin
      unique case (off)
        MMIO_OFF_STATUS:  if (wdata_i[0]) err_d = 1'b0;
        MMIO_OFF_SCRATCH: scratch_d = wdata_i;
        MMIO_OFF_DBG: begin
          dbg_d    = wdata_i;
          strobe_d = 1'b1;
        end
        default: ;
      endcase
    end
    // Reading the counter low byte snapshots the high byte for a later read.
    if (rd_acc && (off == MMIO_OFF_CNT_LO)) shadow_d = counter_q[15:8];
    if (err_set_i) err_d = 1'b1;
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      scratch_q <= '0;
      counter_q <= '0;
      shadow_q  <= '0;
      dbg_q     <= '0;
      strobe_q  <= 1'b0;
    end else begin
      err_q     <= err_d;
      scratch_q <= scratch_d;
      counter_q <= counter_d;
      shadow_q  <= shadow_d;
      dbg_q     <= dbg_d;
      strobe_q  <= strobe_d;
    end
  end

  // Combinational read mux; reserved offsets read as zero.
  always_comb begin
    rdata_o = '0;
    unique case (off)
      MMIO_OFF_STATUS:  rdata_o = DATA_WIDTH'(status_bits(err_q, ready_i));
      MMIO_OFF_SCRATCH: rdata_o = scratch_q;
      MMIO_OFF_CNT_LO:  rdata_o = DATA_WIDTH'(counter_q[7:0]);
      MMIO_OFF_CNT_HI:  rdata_o = DATA_WIDTH'(shadow_q);
      MMIO_OFF_DBG:     rdata_o = dbg_q;
      default:          rdata_o = '0;
    endcase
  end

  assign err_o        = err_q;
  assign dbg_out_o    = dbg_q;
  assign dbg_strobe_o = strobe_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU read/write request interface.
// After reset it sweeps the RAM to zero (CLEAR), then serves zero-wait
// requests (RUN): combinational read data, writes commit on the clock edge.
// Handshake: a request is valid in any cycle where req_rdwr is high; there is
// no per-request ready. The single 'ready' output stays low until the sweep is
// done and is meant to stall the CPU, so no request is accepted in CLEAR.
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = CPU_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH     = CPU_DATA_WIDTH,
  parameter int unsigned           MEM_DEPTH_LOG2 = CPU_MEM_DEPTH_LOG2,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE      = ADDR_WIDTH'(CPU_MMIO_BASE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rdwr,
  input  logic                  which_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dbg_out,
  output logic                  dbg_strobe,
  output logic                  state_dbg   // current FSM state (cmr_state_e)
);

  localparam int unsigned       MEM_DEPTH = 2 ** MEM_DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  cmr_state_e                state_q, state_d;
  logic [MEM_DEPTH_LOG2-1:0] clear_ptr_q, clear_ptr_d;
  logic                      ready_q;

  logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];
  logic                      mem_we;
  logic [MEM_DEPTH_LOG2-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;

  logic                      run_req;
  logic                      req_is_wr;
  logic                      ram_hit;
  logic                      mmio_hit;
  logic                      err_set;
  logic [DATA_WIDTH-1:0]     mmio_rdata;

  // Address decode and request qualification.
  assign ram_hit   = ({1'b0, addr} < MEM_LIMIT);
  assign req_is_wr = (which_rdwr == ENUM__CPU_WH_RDWR__WRITE);
  assign run_req   = (state_q == ST_RUN) && req_rdwr;
  assign err_set   = run_req && !ram_hit && !mmio_hit;

  cpu_mmio_regs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MMIO_BASE  (MMIO_BASE)
  ) u_mmio (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (run_req),
    .we_i         (req_is_wr),
    .addr_i       (addr),
    .wdata_i      (data_in),
    .ready_i      (ready_q),
    .err_set_i    (err_set),
    .rdata_o      (mmio_rdata),
    .hit_o        (mmio_hit),
    .err_o        (err),
    .dbg_out_o    (dbg_out),
    .dbg_strobe_o (dbg_strobe)
  );

  // Next-state and RAM write port: the sweep owns the port in CLEAR,
  // CPU writes to the RAM range own it in RUN.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    mem_we      = 1'b0;
    mem_waddr   = addr[MEM_DEPTH_LOG2-1:0];
    mem_wdata   = data_in;
    case (state_q)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = '0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = req_rdwr && req_is_wr && ram_hit;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // FSM state, sweep pointer and the registered ready flag.
  // ready follows the state one edge later, so it rises on the edge after
  // the last clear write and drops on any reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= (state_q == ST_RUN);
    end
  end

  // RAM storage; contents are initialised by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Zero-wait read data: RAM, MMIO, or 0xFF for unmapped; 0 when idle.
  always_comb begin
    data_out = '0;
    if (run_req && !req_is_wr) begin
      if (ram_hit)       data_out = mem_q[addr[MEM_DEPTH_LOG2-1:0]];
      else if (mmio_hit) data_out = mmio_rdata;
      else               data_out = '1;
    end
  end

  assign ready     = ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus a
// randomized phase, with read data checked through an expected queue.
`timescale 1ns/1ps
module tb_cpu_mem_responder;
  import cpu_mem_responder_pkg::*;

  localparam int DEPTH = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_rdwr;
  logic       which_rdwr;
  logic [15:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       err;
  logic [7:0] dbg_out;
  logic       dbg_strobe;
  logic       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Reference model state.
  logic [7:0] mem_m [DEPTH];
  logic [7:0] scratch_m, shadow_m, dbg_m;
  logic       err_m;
  int         since_rst = 0;   // edges since the last reset edge
  int         strobe_cnt = 0;

  cpu_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_rdwr   (req_rdwr),
    .which_rdwr (which_rdwr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .ready      (ready),
    .err        (err),
    .dbg_out    (dbg_out),
    .dbg_strobe (dbg_strobe),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    scratch_m = 8'h00;
    shadow_m  = 8'h00;
    dbg_m     = 8'h00;
    err_m     = 1'b0;
  endtask

  function automatic logic is_mmio(input logic [15:0] a);
    return (a >= 16'hFF00) && (a < 16'hFF08);
  endfunction

  // Expected read value for a request presented now.
  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [15:0] cnt;
    cnt = 16'(since_rst);
    if (since_rst < DEPTH) return 8'h00;
    if (a < 16'(DEPTH)) return mem_m[a[11:0]];
    if (is_mmio(a)) begin
      case (a - 16'hFF00)
        16'd0:   return {6'b0, (since_rst >= DEPTH + 1), err_m};
        16'd1:   return scratch_m;
        16'd2:   return cnt[7:0];
        16'd3:   return shadow_m;
        16'd4:   return dbg_m;
        default: return 8'h00;
      endcase
    end
    return 8'hFF;
  endfunction

  // Side effects of a request presented now (take effect at the next edge).
  task automatic model_apply(input logic we, input logic [15:0] a, input logic [7:0] d);
    logic [15:0] cnt;
    cnt = 16'(since_rst);
    if (since_rst < DEPTH) return;
    if (a < 16'(DEPTH)) begin
      if (we) mem_m[a[11:0]] = d;
    end else if (is_mmio(a)) begin
      if (we) begin
        if (a == 16'hFF00 && d[0]) err_m = 1'b0;
        if (a == 16'hFF01) scratch_m = d;
        if (a == 16'hFF04) dbg_m = d;
      end else if (a == 16'hFF02) begin
        shadow_m = cnt[15:8];
      end
    end else begin
      err_m = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic we, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    req_rdwr   = 1'b1;
    which_rdwr = we;
    addr       = a;
    data_in    = d;
    if (!we) exp_q.push_back(model_read(a));
    model_apply(we, a, d);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_rdwr   = 1'b0;
    which_rdwr = 1'b0;
    addr       = 16'h0000;
    data_in    = 8'h00;
  endtask

  // Counts edges until ready rises; returns 0 if it never does.
  task automatic wait_ready(output int edge_no);
    edge_no = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        edge_no = k;
        break;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (dbg_strobe === 1'b1) strobe_cnt++;
    if (req_rdwr === 1'b1 && which_rdwr === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: read of 0x%04h with empty expected queue", addr);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL rd_data addr=0x%04h: got 0x%02h, expected 0x%02h", addr, data_out, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rdy_edge;
    int s0;
    rst        = 1'b1;
    req_rdwr   = 1'b0;
    which_rdwr = 1'b0;
    addr       = 16'h0000;
    data_in    = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dbg_out", dbg_out, 8'h00);
    chk("rst_dbg_strobe", dbg_strobe, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_state", state_dbg, ST_CLEAR);
    rst = 1'b0;

    // Ready rise timing; one read issued mid-sweep must return 0.
    rdy_edge = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk); #1;
      if (k == 100) begin
        req_rdwr = 1'b1; which_rdwr = 1'b0; addr = 16'h0010;
        exp_q.push_back(model_read(16'h0010));
      end
      if (k == 101) req_rdwr = 1'b0;
      if (k == DEPTH) chk("ready_low_at_4096", ready, 1'b0);
      if (ready === 1'b1) begin
        rdy_edge = k;
        break;
      end
    end
    chk("ready_rise_edge", rdy_edge, DEPTH + 1);
    chk("run_state", state_dbg, ST_RUN);

    do_req(1'b0, 16'h0000, 8'h00);
    do_req(1'b0, 16'h0FFF, 8'h00);
    idle();

    // Counter low read latches the high byte into the shadow.
    while (since_rst < 16'h12FE) begin @(posedge clk); #1; end
    do_req(1'b0, 16'hFF02, 8'h00);
    idle();
    do_req(1'b0, 16'hFF03, 8'h00);
    idle();

    // Store / load.
    do_req(1'b1, 16'h0010, 8'h45);
    do_req(1'b1, 16'h0011, 8'h87);
    do_req(1'b1, 16'h0012, 8'hAA);
    do_req(1'b0, 16'h0010, 8'h00);
    do_req(1'b0, 16'h0011, 8'h00);
    do_req(1'b0, 16'h0012, 8'h00);
    do_req(1'b1, 16'h0FFF, 8'h3C);
    do_req(1'b0, 16'h0FFF, 8'h00);
    idle();
    chk("err_after_ram", err, 1'b0);

    // Unmapped access, error clear, reserved offsets.
    do_req(1'b0, 16'h2000, 8'h00);
    idle();
    chk("err_set_unmapped_rd", err, 1'b1);
    do_req(1'b1, 16'hFF00, 8'h01);
    idle();
    chk("err_cleared", err, 1'b0);
    do_req(1'b1, 16'h3000, 8'h99);
    do_req(1'b1, 16'hFF00, 8'h00);
    idle();
    chk("err_sticky_wr0", err, 1'b1);
    do_req(1'b1, 16'hFF00, 8'h01);
    do_req(1'b0, 16'hFF10, 8'h00);
    idle();
    chk("err_clear_then_set", err, 1'b1);
    do_req(1'b0, 16'hFF00, 8'h00);
    do_req(1'b1, 16'hFF00, 8'h01);
    do_req(1'b1, 16'hFF05, 8'hAB);
    do_req(1'b0, 16'hFF05, 8'h00);
    do_req(1'b0, 16'hFF07, 8'h00);
    idle();
    chk("err_reserved_none", err, 1'b0);

    // Debug port and strobe.
    do_req(1'b1, 16'hFF04, 8'h5A);
    idle();
    @(negedge clk);
    chk("dbg_strobe_hi", dbg_strobe, 1'b1);
    chk("dbg_out_5a", dbg_out, 8'h5A);
    @(negedge clk);
    chk("dbg_strobe_lo", dbg_strobe, 1'b0);
    s0 = strobe_cnt;
    do_req(1'b1, 16'hFF04, 8'h11);
    do_req(1'b1, 16'hFF04, 8'h22);
    idle();
    repeat (4) idle();
    chk("dbg_two_pulses", strobe_cnt - s0, 2);
    do_req(1'b0, 16'hFF04, 8'h00);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 250; i++) begin
      int kind;
      logic we;
      logic [15:0] a;
      logic [7:0] d;
      kind = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      if (kind <= 4) begin
        a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0FC0, 16'h0FFF))
                                        : 16'($urandom_range(0, 63));
      end else if (kind == 5) begin
        a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h1000, 16'hFEFF))
                                        : 16'($urandom_range(16'hFF08, 16'hFFFF));
      end else begin
        a = 16'hFF00 + 16'($urandom_range(0, 7));
        if (a == 16'hFF02 || a == 16'hFF03) we = 1'b0;
      end
      do_req(we, a, d);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    chk("rand_err", err, err_m);
    chk("rand_dbg_out", dbg_out, dbg_m);

    // Mid-sweep reset after RAM holds 0x77.
    do_req(1'b1, 16'h0000, 8'h77);
    do_req(1'b1, 16'h07FF, 8'h77);
    do_req(1'b1, 16'h0800, 8'h77);
    do_req(1'b1, 16'h0FFF, 8'h77);
    for (int i = 0; i < 32; i++) do_req(1'b1, 16'($urandom_range(0, DEPTH - 1)), 8'h77);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst1_ready_drop", ready, 1'b0);
    chk("rst1_state", state_dbg, ST_CLEAR);
    model_reset();
    rst = 1'b0;
    repeat (2048) begin @(posedge clk); #1; end
    chk("sweep_mid_state", state_dbg, ST_CLEAR);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_ready", ready, 1'b0);
    wait_ready(rdy_edge);
    chk("ready_rise_edge_2", rdy_edge, DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, 16'(i), 8'h00);
    idle();
    chk("err_after_restart", err, 1'b0);

    // Counter wrap 0xFFFF -> 0x0000.
    while (since_rst < 16'hFFFE) begin @(posedge clk); #1; end
    do_req(1'b0, 16'hFF02, 8'h00);
    do_req(1'b0, 16'hFF02, 8'h00);
    do_req(1'b0, 16'hFF03, 8'h00);
    idle();
    repeat (2) idle();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
